div_seq: RTL and testbench

Iterative unsigned restoring divider for the execute stage of the pipelined CPU. It is the inverse counterpart of the carry-select adder slices. It takes a dividend and divisor through a start/busy handshake and runs one subtract-and-shift step per clock. It returns quotient and remainder with a one-cycle done pulse. Each step uses a borrow-chain subtractor, so the block stays off the single-cycle ALU critical path.

---
 rtl/div_pkg.sv | 5 +
 rtl/div_sub_step.sv | 13 +
 rtl/div_seq.sv | 68 ++++++
 tb/tb_div_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and divide-by-zero quotient constant for div_seq
package div_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} div_state_t;
    localparam logic [63:0] DIV_DZ_QUOT = '1;
endpackage

// File: rtl/div_sub_step.sv
// div_sub_step: WIDTH+1-bit trial subtract (partial + ~divisor + 1) giving difference and borrow
module div_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);
    logic carry;
    assign {carry, diff} = {1'b0, partial} + {1'b0, ~{1'b0, divisor}} + (WIDTH+2)'(1);
    assign borrow = ~carry;
endmodule

// File: rtl/div_seq.sv
// div_seq: iterative unsigned restoring divider, start/busy handshake, one step per clock, done pulse with quotient/remainder/dz
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             dz_o
);
    localparam int CW = $clog2(WIDTH);
    div_state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] dvd, dvs, quot;
    logic [WIDTH:0] rem, shifted, diff;
    logic borrow, dz, unused_msb;
    assign unused_msb = rem[WIDTH];
    assign shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .partial(shifted),
        .divisor(dvs),
        .diff(diff),
        .borrow(borrow)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            quot  <= '0;
            rem   <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    dvd   <= dividend_i;
                    dvs   <= divisor_i;
                    cnt   <= CW'(WIDTH-1);
                    dz    <= divisor_i == '0;
                    quot  <= divisor_i == '0 ? DIV_DZ_QUOT[WIDTH-1:0] : '0;
                    rem   <= divisor_i == '0 ? {1'b0, dividend_i} : '0;
                    state <= divisor_i == '0 ? DONE : RUN;
                end
                RUN: begin
                    dvd   <= dvd << 1;
                    rem   <= borrow ? shifted : diff;
                    quot  <= {quot[WIDTH-2:0], ~borrow};
                    cnt   <= cnt - CW'(1);
                    state <= cnt == '0 ? DONE : RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy_o      = state != IDLE;
    assign done_o      = state == DONE;
    assign quotient_o  = quot;
    assign remainder_o = rem[WIDTH-1:0];
    assign dz_o        = dz;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and random self-checking bench for div_seq at WIDTH 8 and 32
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0, start32 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;
  logic [31:0] a32 = '0, b32 = '0, q32, r32;
  logic busy8, done8, dz8, busy32, done32, dz32;
  int cmp = 0;
  int err = 0;
  always #5 clk = ~clk;
  div_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .dividend_i(a8), .divisor_i(b8),
    .busy_o(busy8), .done_o(done8), .quotient_o(q8), .remainder_o(r8), .dz_o(dz8)
  );
  div_seq #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .dividend_i(a32), .divisor_i(b32),
    .busy_o(busy32), .done_o(done32), .quotient_o(q32), .remainder_o(r32), .dz_o(dz32)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    if (obs !== exp) begin
      err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input logic edz, input int lat);
    start8 = 1'b1; a8 = a; b8 = b;
    tick();
    start8 = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      chk("busy8", busy8, 1'b1);
      chk("done8", done8, k == lat);
      if (k == lat) begin
        chk("quot8", q8, eq);
        chk("rem8", r8, er);
        chk("dz8", dz8, edz);
      end
      tick();
    end
    chk("busy8_after", busy8, 1'b0);
    chk("done8_after", done8, 1'b0);
  endtask
  task automatic run32(input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic early;
    lat = b == 0 ? 1 : 33;
    early = 1'b0;
    start32 = 1'b1; a32 = a; b32 = b;
    tick();
    start32 = 1'b0;
    for (int k = 1; k < lat; k++) begin
      early = early | done32 | ~busy32;
      tick();
    end
    chk("early32", early, 1'b0);
    chk("done32", done32, 1'b1);
    chk("quot32", q32, b == 0 ? 32'hFFFF_FFFF : a / b);
    chk("rem32", r32, b == 0 ? a : a % b);
    chk("dz32", dz32, b == 0);
    tick();
    chk("idle32", busy32, 1'b0);
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic seen;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_quot", q8, 8'd0);
    chk("rst_rem", r8, 8'd0);
    chk("rst_dz", dz8, 1'b0);
    run8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    run8(8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1);
    run8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run8(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 9);
    run8(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    tick();
    start8 = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
    tick();
    start8 = 1'b0;
    for (int k = 5; k < 9; k++) tick();
    chk("ign_done", done8, 1'b1);
    chk("ign_quot", q8, 8'd14);
    chk("ign_rem", r8, 8'd2);
    tick();
    chk("ign_idle", busy8, 1'b0);
    run8(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd9;
    tick();
    start8 = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_done", done8, 1'b0);
    chk("mid_rst_quot", q8, 8'd0);
    chk("mid_rst_rem", r8, 8'd0);
    chk("mid_rst_dz", dz8, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen = seen | done8 | busy8;
      tick();
    end
    chk("mid_rst_no_done", seen, 1'b0);
    run8(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 9);
    run32(32'd100, 32'd7);
    run32(32'hFFFF_FFFF, 32'd0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = i % 5 == 0 ? 32'd0 : i % 5 == 2 ? $urandom_range(1, 255) : $urandom;
      if (i % 5 == 1) begin
        ra = $urandom_range(0, 1000);
        rb = $urandom_range(1001, 100000);
      end
      run32(ra, rb);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
